rv32i_multicycle_control_unit: RTL and testbench

- Parametrised multicycle successor to the single-cycle control decoder.
- An FSM sequences fetch, decode, execute, memory and writeback over several cycles for the full RV32I base subset below. Supported: R/I-ALU, LB/LH/LW/LBU/LHU, SB/SH/SW, all six branches, JAL, JALR, LUI, AUIPC.
- Drives a shared-memory multicycle datapath. Adds a memory ready handshake, illegal-instruction trap handling and a retired-instruction counter.

---
 rtl/rv32i_multicycle_control_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_rv32i_multicycle_control_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_control_unit.sv
// rv32i_multicycle_control_unit
// Control FSM for a shared-memory multicycle RV32I datapath. It sequences
// fetch/decode/execute/memory/writeback, waits on the memory handshake,
// traps on unsupported encodings and counts retired instructions.
module rv32i_multicycle_control_unit #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_HALT     = 1'b1,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [3:0]           ALUControl,
    output logic [1:0]           ResultSrc,
    output logic [2:0]           ImmSrc,
    output logic [2:0]           AddressingControl,
    output logic                 illegal,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] instret,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALR     = 4'd10,
        S_JUMP     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14,
        S_UNUSED   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   instret_reg;
    logic                   ready;
    logic                   br_taken;

    // SUB only exists for register-register ops; bit 30 always selects SRA.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // A memory access completes this cycle when the memory says so, or always when the handshake is disabled.
    assign ready   = mem_ready || !MEM_HANDSHAKE;
    assign illegal = (state_reg == S_TRAP);
    assign instret = instret_reg;
    assign state   = state_reg;

    // Branch condition: odd funct3 codes invert the base comparison.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // Datapath controls and next state as a function of the current state and inputs.
    always_comb begin
        PCWrite           = 1'b0;
        IRWrite           = 1'b0;
        AdrSrc            = 1'b0;
        MemRead           = 1'b0;
        MemWrite          = 1'b0;
        RegWrite          = 1'b0;
        ALUSrcA           = 2'b00;
        ALUSrcB           = 2'b00;
        ALUControl        = ALU_ADD;
        ResultSrc         = 2'b00;
        ImmSrc            = IMM_I;
        AddressingControl = 3'b000;
        retire            = 1'b0;
        state_next        = state_reg;
        case (state_reg)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                PCWrite   = ready;
                if (ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD:  begin ImmSrc = IMM_I; state_next = S_MEMADR;   end
                    OP_STORE: begin ImmSrc = IMM_S; state_next = S_MEMADR;   end
                    OP_R:     begin ImmSrc = IMM_I; state_next = S_EXECUTER; end
                    OP_I:     begin ImmSrc = IMM_I; state_next = S_EXECUTEI; end
                    OP_BR:    begin ImmSrc = IMM_B; state_next = S_BRANCH;   end
                    OP_JAL:   begin ImmSrc = IMM_J; state_next = S_JUMP;     end
                    OP_JALR:  begin ImmSrc = IMM_I; state_next = S_JALR;     end
                    OP_LUI:   begin ImmSrc = IMM_U; state_next = S_LUI;      end
                    OP_AUIPC: begin ImmSrc = IMM_U; state_next = S_AUIPC;    end
                    default:  begin ImmSrc = IMM_I; state_next = S_TRAP;     end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
                state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc            = 1'b1;
                MemRead           = 1'b1;
                AddressingControl = funct3;
                if (ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc            = 1'b1;
                MemWrite          = 1'b1;
                AddressingControl = funct3;
                retire            = ready;
                if (ready) state_next = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7_5, 1'b1);
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct3, funct7_5, 1'b0);
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                // funct3 010/011 are not branch encodings.
                if (funct3[2:1] == 2'b01) begin
                    state_next = S_TRAP;
                end else begin
                    PCWrite    = br_taken;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = S_JUMP;
            end
            S_JUMP: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                ImmSrc     = IMM_U;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ImmSrc     = IMM_U;
                state_next = S_ALUWB;
            end
            S_TRAP: begin
                state_next = TRAP_HALT ? S_TRAP : S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
        // Reset abandons the current instruction without side effects.
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            retire   = 1'b0;
        end
    end

    // State register and retired-instruction counter (wraps naturally).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) instret_reg <= instret_reg + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_control_unit.sv
// Self-checking bench for rv32i_multicycle_control_unit. Two instances with
// different parameters share the instruction inputs; the one not under test
// is held in reset. Each instruction's state path is derived from its class
// and every cycle's outputs are compared with the expected control word.
module tb_rv32i_multicycle_control_unit;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       adr;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] alu;
        logic [1:0] rs;
        logic [2:0] imm;
        logic [2:0] ac;
        logic       ill;
        logic       ret;
        logic [3:0] st;
    } obs_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0_n, rst1_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5, zero, lt, ltu, mem_ready;
    logic       sel;
    int         checks = 0;
    int         failures = 0;
    logic [31:0] model_cnt;

    // Instance 0: handshake on, halting trap, 4-bit counter.
    logic pcw0, irw0, adr0, mr0, mw0, rw0, ill0, ret0;
    logic [1:0] sa0, sb0, rs0;
    logic [3:0] alu0, st0;
    logic [2:0] imm0, ac0;
    logic [3:0] cnt0;
    // Instance 1: handshake off, non-halting trap, 32-bit counter.
    logic pcw1, irw1, adr1, mr1, mw1, rw1, ill1, ret1;
    logic [1:0] sa1, sb1, rs1;
    logic [3:0] alu1, st1;
    logic [2:0] imm1, ac1;
    logic [31:0] cnt1;

    rv32i_multicycle_control_unit #(.MEM_HANDSHAKE(1'b1), .TRAP_HALT(1'b1), .CNT_WIDTH(4)) u0 (
        .clk(clk), .rst_n(rst0_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .PCWrite(pcw0), .IRWrite(irw0), .AdrSrc(adr0), .MemRead(mr0), .MemWrite(mw0),
        .RegWrite(rw0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUControl(alu0), .ResultSrc(rs0),
        .ImmSrc(imm0), .AddressingControl(ac0), .illegal(ill0), .retire(ret0),
        .instret(cnt0), .state(st0));

    rv32i_multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .TRAP_HALT(1'b0), .CNT_WIDTH(32)) u1 (
        .clk(clk), .rst_n(rst1_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .PCWrite(pcw1), .IRWrite(irw1), .AdrSrc(adr1), .MemRead(mr1), .MemWrite(mw1),
        .RegWrite(rw1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(alu1), .ResultSrc(rs1),
        .ImmSrc(imm1), .AddressingControl(ac1), .illegal(ill1), .retire(ret1),
        .instret(cnt1), .state(st1));

    obs_t o0, o1, obs;
    logic [31:0] cnt_obs;
    assign o0 = {pcw0, irw0, adr0, mr0, mw0, rw0, sa0, sb0, alu0, rs0, imm0, ac0, ill0, ret0, st0};
    assign o1 = {pcw1, irw1, adr1, mr1, mw1, rw1, sa1, sb1, alu1, rs1, imm1, ac1, ill1, ret1, st1};
    assign obs     = sel ? o1 : o0;
    assign cnt_obs = sel ? cnt1 : {28'd0, cnt0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t en_mask();
        obs_t m = '0;
        m.pcw = 1'b1; m.irw = 1'b1; m.mr = 1'b1; m.mw = 1'b1; m.rw = 1'b1; m.ret = 1'b1;
        return m;
    endfunction

    function automatic logic [2:0] imm_for(input logic [6:0] o);
        if (o == OP_STORE) return 3'b001;
        if (o == OP_BR) return 3'b010;
        if (o == OP_JAL) return 3'b011;
        if (o == OP_LUI || o == OP_AUIPC) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [3:0] alu_ref(input logic is_r);
        logic [3:0] tbl [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (funct3 == 3'b000 && is_r && funct7_5) return 4'd1;
        if (funct3 == 3'b101 && funct7_5) return 4'd11;
        return tbl[funct3];
    endfunction

    // Expected control word for one cycle spent in spec state s.
    function automatic obs_t exp_out(input int s, input logic rdy);
        obs_t e = '0;
        logic [7:0] cond;
        cond = {~ltu, ltu, ~lt, lt, 1'b0, 1'b0, ~zero, zero};
        case (s)
            0:  begin e.mr = 1; e.sb = 2'b10; e.rs = 2'b10; e.pcw = rdy; e.irw = rdy; end
            1:  begin e.sa = 2'b01; e.sb = 2'b01; e.imm = imm_for(op); end
            2:  begin e.sa = 2'b10; e.sb = 2'b01; e.imm = (op == OP_STORE) ? 3'b001 : 3'b000; end
            3:  begin e.adr = 1; e.mr = 1; e.ac = funct3; end
            4:  begin e.rs = 2'b01; e.rw = 1; e.ret = 1; end
            5:  begin e.adr = 1; e.mw = 1; e.ac = funct3; e.ret = rdy; end
            6:  begin e.sa = 2'b10; e.alu = alu_ref(1'b1); end
            7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_ref(1'b0); end
            8:  begin e.rw = 1; e.ret = 1; end
            9:  begin
                    e.sa = 2'b10; e.alu = 4'b0001;
                    if (funct3[2:1] != 2'b01) begin e.pcw = cond[funct3]; e.ret = 1; end
                end
            10: begin e.sa = 2'b10; e.sb = 2'b01; end
            11: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
            12: begin e.sa = 2'b11; e.sb = 2'b01; e.imm = 3'b100; end
            13: begin e.sa = 2'b01; e.sb = 2'b01; e.imm = 3'b100; end
            default: e.ill = 1;
        endcase
        e.st = 4'(s);
        return e;
    endfunction

    task automatic set_rst(input logic v);
        if (sel) rst1_n = v; else rst0_n = v;
    endtask

    task automatic select_dut(input logic which);
        rst0_n = 1'b0; rst1_n = 1'b0; sel = which; mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_enables", 64'(obs & en_mask()), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_state", 64'(obs.st), 64'd0);
        chk("rst_illegal", 64'(obs.ill), 64'd0);
        chk("rst_instret", 64'(cnt_obs), 64'd0);
        @(posedge clk); #1;
        set_rst(1'b1);
        model_cnt = 0;
    endtask

    // Runs one instruction. wait_fix >= 0 fixes the stall count of every memory
    // state, -1 randomises it; abort_at >= 0 pulls reset at that path step.
    task automatic run_instr(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                             input logic iz, input logic ilt, input logic iltu,
                             input int wait_fix, input int abort_at);
        int path[$];
        int waits;
        logic hs, halt, rdy;
        logic [31:0] mask;
        obs_t e;
        hs = !sel; halt = !sel;
        mask = sel ? 32'hFFFF_FFFF : 32'h0000_000F;
        op = iop; funct3 = if3; funct7_5 = if7; zero = iz; lt = ilt; ltu = iltu;
        case (iop)
            OP_LOAD:  path = '{0, 1, 2, 3, 4};
            OP_STORE: path = '{0, 1, 2, 5};
            OP_R:     path = '{0, 1, 6, 8};
            OP_I:     path = '{0, 1, 7, 8};
            OP_BR:    if (if3[2:1] == 2'b01) path = '{0, 1, 9, 14}; else path = '{0, 1, 9};
            OP_JAL:   path = '{0, 1, 11, 8};
            OP_JALR:  path = '{0, 1, 10, 11, 8};
            OP_LUI:   path = '{0, 1, 12, 8};
            OP_AUIPC: path = '{0, 1, 13, 8};
            default:  path = '{0, 1, 14};
        endcase
        for (int k = 0; k < path.size(); k++) begin
            if (k == abort_at) begin
                mem_ready = 1'b1;
                set_rst(1'b0);
                @(negedge clk);
                e = exp_out(path[k], 1'b1);
                e.pcw = 0; e.irw = 0; e.mr = 0; e.mw = 0; e.rw = 0; e.ret = 0;
                chk($sformatf("abort st%0d", path[k]), 64'(obs), 64'(e));
                @(posedge clk); #1;
                set_rst(1'b1);
                model_cnt = 0;
                return;
            end
            if (!hs || !(path[k] == 0 || path[k] == 3 || path[k] == 5)) waits = 0;
            else if (wait_fix >= 0) waits = wait_fix;
            else waits = int'($urandom_range(0, 3));
            for (int w = 0; w <= waits; w++) begin
                rdy = (w == waits);
                mem_ready = hs ? rdy : 1'($urandom_range(0, 1));
                @(negedge clk);
                e = exp_out(path[k], hs ? rdy : 1'b1);
                chk($sformatf("op%b f3%b st%0d w%0d", iop, if3, path[k], w), 64'(obs), 64'(e));
                if (k == 0 && w == 0) chk("instret", 64'(cnt_obs), 64'(model_cnt & mask));
                @(posedge clk); #1;
                if (e.ret) model_cnt = model_cnt + 1;
            end
        end
        if (path[path.size()-1] == 14 && halt) begin
            for (int h = 0; h < 10; h++) begin
                mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk($sformatf("trap_hold %0d", h), 64'(obs), 64'(exp_out(14, 1'b1)));
                @(posedge clk); #1;
            end
            set_rst(1'b0);
            @(negedge clk);
            chk("trap_rst", 64'(obs), 64'(exp_out(14, 1'b1)));
            @(posedge clk); #1;
            set_rst(1'b1);
            model_cnt = 0;
        end
    endtask

    task automatic run_random(input int n);
        logic [6:0] ops [11] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR,
                                 OP_LUI, OP_AUIPC, OP_FENCE, OP_SYS};
        for (int i = 0; i < n; i++) begin
            run_instr(ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      -1, -1);
        end
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0; sel = 1'b0;
        op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        mem_ready = 1'b0; model_cnt = 0;

        // Handshaking instance.
        select_dut(1'b0);
        run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3, -1);      // lw with 3 stall cycles
        run_instr(OP_BR, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);        // bge, lt=1: not taken
        run_instr(OP_BR, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);        // bge, lt=0: taken
        run_instr(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        run_instr(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1);         // sub
        run_instr(OP_I, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1);         // srai
        run_instr(OP_STORE, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3);      // sh, reset in MEMWRITE
        for (int i = 0; i < 16; i++)
            run_instr(OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);     // 16 retires wrap 4-bit count
        run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        run_instr(OP_FENCE, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);     // halting trap
        run_instr(OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        run_random(60);

        // Non-handshaking, non-halting instance.
        select_dut(1'b1);
        run_instr(OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);         // addi x1,x0,5
        run_instr(OP_LOAD, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        run_instr(OP_FENCE, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);     // trap then FETCH
        run_instr(OP_BR, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 0, -1);        // bad branch funct3
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        run_random(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
